clkspec_shres2: RTL



---
 rtl/clkspec_shres2_pkg.sv | 17 +
 rtl/clkspec_shres2_if.sv | 25 ++
 rtl/clkspec_rrarb2.sv | 16 +
 rtl/clkspec_shres2.sv | 106 ++++++++++
 4 files changed

// File: rtl/clkspec_shres2_pkg.sv
// Shared definitions for the two-client shared-resource responder.
//   shres_state_e : responder FSM encoding (IDLE/EXEC/RESP)
//   client_idx_t  : index of a client (0 or 1)
//   CNT_W         : width of the optional per-client grant counters
package clkspec_shres2_pkg;

    typedef enum logic [1:0] {
        SHRES_IDLE = 2'b00,
        SHRES_EXEC = 2'b01,
        SHRES_RESP = 2'b10
    } shres_state_e;

    typedef logic client_idx_t;

    localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/clkspec_shres2_if.sv
// One client's request/response channel to the shared responder.
//   req_valid/req_ready : operand handshake (a, b)
//   rsp_valid/rsp_ready : result handshake (y)
// master = client side, slave = responder side.
interface clkspec_shres2_if #(
    parameter int unsigned WIDTH = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] y;

    modport master (
        output req_valid, a, b, rsp_ready,
        input  req_ready, rsp_valid, y
    );

    modport slave (
        input  req_valid, a, b, rsp_ready,
        output req_ready, rsp_valid, y
    );
endinterface

// File: rtl/clkspec_rrarb2.sv
// Combinational 2-way round-robin grant.
//   r0, r1   : requests
//   last_gnt : client granted most recently (held by the parent)
//   g0, g1   : one-hot grant; on contention the client other than last_gnt wins
module clkspec_rrarb2
    import clkspec_shres2_pkg::*;
(
    input  logic        r0,
    input  logic        r1,
    input  client_idx_t last_gnt,
    output logic        g0,
    output logic        g1
);
    assign g0 = r0 & (~r1 | last_gnt);
    assign g1 = r1 & (~r0 | ~last_gnt);
endmodule

// File: rtl/clkspec_shres2.sv
// Two-client shared adder responder.
// Arbitrates between two clients, captures the winner's operands, adds them in
// one cycle (carry dropped) and returns the result only to the requester.
//   clk, reset      : clock, asynchronous active-low reset
//   c0, c1          : per-client request/response channels (slave side)
//   busy            : high whenever the FSM is not idle
//   gnt_cnt0/1      : saturating accepted-request counters, present only when
//                     SHRES_GNTCNT_EN is defined
module clkspec_shres2
    import clkspec_shres2_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    clkspec_shres2_if.slave      c0,
    clkspec_shres2_if.slave      c1,
`ifdef SHRES_GNTCNT_EN
    output logic [CNT_W-1:0]     gnt_cnt0,
    output logic [CNT_W-1:0]     gnt_cnt1,
`endif
    output logic                 busy
);
    shres_state_e     state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, y_q;
    client_idx_t      owner_q, last_gnt_q;

    logic g0, g1;
    logic idle, accept, owner_rsp_ready, resp0, resp1;

    clkspec_rrarb2 u_arb (
        .r0       (c0.req_valid),
        .r1       (c1.req_valid),
        .last_gnt (last_gnt_q),
        .g0       (g0),
        .g1       (g1)
    );

    assign idle            = (state_q == SHRES_IDLE);
    assign accept          = idle & (g0 | g1);
    assign owner_rsp_ready = owner_q ? c1.rsp_ready : c0.rsp_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SHRES_IDLE: if (g0 | g1) state_d = SHRES_EXEC;
            SHRES_EXEC: state_d = SHRES_RESP;
            SHRES_RESP: if (owner_rsp_ready) state_d = SHRES_IDLE;
            default:    state_d = SHRES_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= SHRES_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            y_q        <= '0;
            owner_q    <= 1'b0;
            last_gnt_q <= 1'b1;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q     <= g1 ? c1.a : c0.a;
                b_q     <= g1 ? c1.b : c0.b;
                owner_q <= g1;
            end
            if (state_q == SHRES_EXEC) begin
                y_q <= a_q + b_q;
            end
            if ((state_q == SHRES_RESP) && owner_rsp_ready) begin
                last_gnt_q <= owner_q;
            end
        end
    end

    // Ready is masked by reset so nothing looks accepted while reset is held.
    assign c0.req_ready = reset & idle & g0;
    assign c1.req_ready = reset & idle & g1;

    assign resp0        = (state_q == SHRES_RESP) & ~owner_q;
    assign resp1        = (state_q == SHRES_RESP) & owner_q;
    assign c0.rsp_valid = resp0;
    assign c1.rsp_valid = resp1;
    assign c0.y         = resp0 ? y_q : '0;
    assign c1.y         = resp1 ? y_q : '0;

    assign busy = ~idle;

`ifdef SHRES_GNTCNT_EN
    logic [CNT_W-1:0] cnt0_q, cnt1_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (accept && g0 && (cnt0_q != '1)) cnt0_q <= cnt0_q + 1'b1;
            if (accept && g1 && (cnt1_q != '1)) cnt1_q <= cnt1_q + 1'b1;
        end
    end

    assign gnt_cnt0 = cnt0_q;
    assign gnt_cnt1 = cnt1_q;
`endif
endmodule
